cache_nway: RTL and testbench
=============================

Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Sits between the CPU memory port and the cacheline adaptor; the two sides speak the same interfaces as the current cache.
- Generalises the two-way design in three ways:
  - configurable way count with tree pseudo-LRU replacement;
  - invalid-way-first victim selection;
  - saturating hit/miss performance counters.
- Controller, tag/valid/dirty/PLRU arrays, data array and byte-enable merge are all internal to this block.

Parameters:
- s_offset, 5, byte-offset bits; line is 2**s_offset bytes. Only 5 is supported (256-bit line).
- s_index, 3, set-index bits; num_sets = 2**s_index.
- s_tag, 32-s_offset-s_index, tag width.
- num_ways, 4, associativity; power of two, 2..8.
- s_way, log2(num_ways), way-select width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_address  in  32  CPU byte address.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_wdata  in  32  CPU write data.
- mem_byte_enable  in  4  byte lanes of mem_wdata to write.
- mem_rdata  out  32  read word; valid while mem_resp is high.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  in  256  fill line from the adaptor.
- pmem_resp  in  1  adaptor completion pulse.
- pmem_address  out  32  line-aligned memory address.
- pmem_read  out  1  line read request.
- pmem_write  out  1  line write request.
- pmem_wdata  out  256  victim line for write-back.
- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of misses.

Behaviour:
- Reset (rst=0, asynchronous):
  - all valid, dirty and PLRU bits cleared;
  - state forced to CHECK;
  - mem_resp, pmem_read and pmem_write forced to 0 immediately;
  - hit_count and miss_count forced to 0;
  - mem_rdata, pmem_wdata and pmem_address are don't-care until the first request.
  - Reset mid-transaction abandons it; no response is owed afterwards.
- Address split: tag = [31:s_offset+s_index], index = [s_offset+s_index-1:s_offset], word = [4:2].
- States: CHECK, WRITEBACK, FILL.
- CHECK:
  - The set is looked up combinationally; a way hits when it is valid and its tag matches.
  - Hit, read: mem_resp=1 in the same cycle; mem_rdata = the selected 32-bit word.
  - Hit, write: mem_resp=1 in the same cycle. On the clock edge, bytes with mem_byte_enable[i]=1 are merged into the word and the way's dirty bit is set.
  - On every hit, at the edge: PLRU for the set is updated to point away from the hit way, and hit_count increments.
  - Miss with a request present: miss_count increments once and a victim is chosen.
    - Victim is the lowest-numbered invalid way if any; otherwise the PLRU victim.
    - The victim is latched for the whole miss.
    - Next state is WRITEBACK if the victim is valid and dirty, else FILL.
  - No request: stay in CHECK with no side effects.
- WRITEBACK:
  - pmem_write=1.
  - pmem_address = {victim tag, index, 5'b0}.
  - pmem_wdata = victim line, held constant.
  - On pmem_resp: clear the victim's dirty bit and go to FILL.
- FILL:
  - pmem_read=1.
  - pmem_address = {request tag, index, 5'b0}.
  - On pmem_resp, at the edge: write pmem_rdata into the victim way, write the tag, set valid, clear dirty, update PLRU, and go to CHECK.
  - The request then hits in the next cycle. Miss latency is therefore fill cycles + 1, plus the write-back cycles if the victim was dirty.
- pmem_read and pmem_write are never asserted together.
- Request withdrawn mid-miss: the line transaction still completes; no mem_resp is issued if no request is present in CHECK.
- mem_read and mem_write both high: treated as a write.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- A miss is counted once, even though its retry later counts as a hit.
- Tree PLRU: num_ways-1 bits per set. Each node bit points to the less-recently-used subtree.

Test Plan:
- Cold read of 0x0000_0040:
  - required: one FILL with pmem_address=0x0000_0040 and no WRITEBACK;
  - mem_resp one cycle after pmem_resp;
  - miss_count=1, hit_count=1;
  - mem_rdata equals the matching word of pmem_rdata.
- Write 0xDEADBEEF, be=4'b0101, to a resident word holding 0x11223344:
  - mem_resp in the same cycle;
  - a following read returns 0x11AD33EF;
  - no pmem traffic.
- num_ways=4: fill set 0 with tags A,B,C,D; touch A; miss on tag E:
  - the victim must be B;
  - no WRITEBACK, since B is clean.
- Dirty victim:
  - write to tag B, then force its eviction;
  - required: WRITEBACK to B's line with the merged data, then FILL of the new line, in that order, never overlapping.
- Assert rst during FILL with pmem_read=1:
  - pmem_read drops without waiting for a clock;
  - after release the same address misses again;
  - counters read 0.
- Preload hit_count to 32'hFFFF_FFFE through back-door force, then issue 3 hits:
  - hit_count = 32'hFFFF_FFFF and holds.

Source files
------------

// File: rtl/cache_nway.sv
// N-way set-associative, write-back / write-allocate cache with tree pseudo-LRU
// replacement, invalid-way-first victim choice and saturating hit/miss counters.
module cache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_tag    = 32 - s_offset - s_index,
    parameter int num_ways = 4,
    parameter int s_way    = $clog2(num_ways)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int num_sets  = 2 ** s_index;
    localparam int s_line    = 8 * (2 ** s_offset);
    localparam int num_nodes = num_ways - 1;

    typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_e;

    state_e                 state_q;
    logic                   pmem_read_q, pmem_write_q;
    logic [s_tag-1:0]       miss_tag_q;
    logic [s_index-1:0]     miss_idx_q;
    logic [s_way-1:0]       victim_q;
    logic [31:0]            hit_count_q, hit_count_d;
    logic [31:0]            miss_count_q, miss_count_d;

    logic [s_tag-1:0]       tag_q   [num_sets][num_ways];
    logic [s_line-1:0]      data_q  [num_sets][num_ways];
    logic [num_ways-1:0]    valid_q [num_sets];
    logic [num_ways-1:0]    dirty_q [num_sets];
    logic [num_nodes-1:0]   plru_q  [num_sets];

    // Tree walk uses way bit l at level l (LSB first); node n has children 2n+1 / 2n+2.
    function automatic logic [s_way-1:0] plru_victim(input logic [num_nodes-1:0] bits);
        int               node;
        logic [s_way-1:0] v;
        node = 0;
        v    = '0;
        for (int l = 0; l < s_way; l++) begin
            v[l] = bits[node];
            node = 2 * node + (bits[node] ? 2 : 1);
        end
        return v;
    endfunction

    function automatic logic [num_nodes-1:0] plru_touch(input logic [num_nodes-1:0] bits,
                                                        input logic [s_way-1:0]     way);
        int                   node;
        logic [num_nodes-1:0] r;
        node = 0;
        r    = bits;
        for (int l = 0; l < s_way; l++) begin
            r[node] = ~way[l];
            node    = 2 * node + (way[l] ? 2 : 1);
        end
        return r;
    endfunction

    logic [s_tag-1:0]   req_tag;
    logic [s_index-1:0] req_idx;
    logic [2:0]         req_word;
    logic [7:0]         word_lsb;
    logic               req;
    logic               unused_addr_bits;

    assign req_tag          = mem_address[31 -: s_tag];
    assign req_idx          = mem_address[s_offset +: s_index];
    assign req_word         = mem_address[4:2];
    assign word_lsb         = {req_word, 5'd0};
    assign req              = mem_read | mem_write;
    assign unused_addr_bits = ^mem_address[1:0];

    logic             hit, has_inv;
    logic [s_way-1:0] hit_way, inv_way, victim_sel;
    logic             victim_dirty;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = s_way'(w);
            end
            if (!valid_q[req_idx][w]) begin
                has_inv = 1'b1;
                inv_way = s_way'(w);
            end
        end
    end

    assign victim_sel   = has_inv ? inv_way : plru_victim(plru_q[req_idx]);
    assign victim_dirty = valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel];

    logic hit_ev, miss_ev, wb_done, fill_done;

    assign hit_ev    = (state_q == CHECK) && req && hit;
    assign miss_ev   = (state_q == CHECK) && req && !hit;
    assign wb_done   = (state_q == WRITEBACK) && pmem_resp;
    assign fill_done = (state_q == FILL) && pmem_resp;

    logic [s_line-1:0] hit_line, merged_line;

    assign hit_line = data_q[req_idx][hit_way];

    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b])
                merged_line[word_lsb + 8 * b +: 8] = mem_wdata[8 * b +: 8];
        end
    end

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_ev && hit_count_q != 32'hFFFF_FFFF)
            hit_count_d = hit_count_q + 32'd1;
        if (miss_ev && miss_count_q != 32'hFFFF_FFFF)
            miss_count_d = miss_count_q + 32'd1;
    end

    // Controller: the miss context (tag, set, victim) is latched so a withdrawn
    // or changed request cannot disturb the line transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CHECK;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            case (state_q)
                CHECK: begin
                    if (miss_ev) begin
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        victim_q   <= victim_sel;
                        if (victim_dirty) begin
                            state_q      <= WRITEBACK;
                            pmem_write_q <= 1'b1;
                        end else begin
                            state_q     <= FILL;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_q      <= FILL;
                        pmem_write_q <= 1'b0;
                        pmem_read_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state_q     <= CHECK;
                        pmem_read_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= CHECK;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (hit_ev) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                if (mem_write)
                    dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (wb_done)
                dirty_q[miss_idx_q][victim_q] <= 1'b0;
            if (fill_done) begin
                valid_q[miss_idx_q][victim_q] <= 1'b1;
                dirty_q[miss_idx_q][victim_q] <= 1'b0;
                plru_q[miss_idx_q]            <= plru_touch(plru_q[miss_idx_q], victim_q);
            end
        end
    end

    // Payload arrays carry no reset; the valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (hit_ev && mem_write)
            data_q[req_idx][hit_way] <= merged_line;
        if (fill_done) begin
            data_q[miss_idx_q][victim_q] <= pmem_rdata;
            tag_q[miss_idx_q][victim_q]  <= miss_tag_q;
        end
    end

    assign mem_resp     = hit_ev;
    assign mem_rdata    = hit_line[word_lsb +: 32];
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_wdata   = data_q[miss_idx_q][victim_q];
    assign pmem_address = (state_q == WRITEBACK)
                        ? {tag_q[miss_idx_q][victim_q], miss_idx_q, {s_offset{1'b0}}}
                        : {miss_tag_q, miss_idx_q, {s_offset{1'b0}}};
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_cache_nway.sv
// Scoreboard bench for cache_nway: CPU responses and line transactions are
// checked against queues of expected results filled by the directed sequence.
module tb_cache_nway;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  mem_address = '0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0]  mem_wdata = '0;
    logic [3:0]   mem_byte_enable = '0;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [31:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [255:0] pmem_wdata;
    logic [31:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    cache_nway dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct { logic is_rd; logic [31:0] rdata; string name; } rsp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [255:0] data; } pop_t;

    rsp_t exp_q[$];
    pop_t pexp_q[$];
    int   errors = 0, checks = 0;
    int   cyc = 0, resp_cyc = 0, presp_cyc = 0, pmem_ops = 0;
    logic [31:0] mem [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = rd_word(a + 32'(4 * w));
        return l;
    endfunction

    // Line adaptor model plus line-transaction scoreboard.
    initial begin
        pop_t e;
        logic aborted;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst && (pmem_read || pmem_write)) begin
                pmem_ops++;
                chk32("pmem_no_overlap", 32'(pmem_read && pmem_write), 32'd0);
                if (pexp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pmem_unexpected: got op at %h expected none", pmem_address);
                    e.wr = pmem_write; e.addr = pmem_address; e.data = pmem_wdata;
                end else begin
                    e = pexp_q.pop_front();
                    chk32("pmem_is_write", 32'(pmem_write), 32'(e.wr));
                    chk32("pmem_address", pmem_address, e.addr);
                    if (e.wr) chk256("pmem_wdata", pmem_wdata, e.data);
                end
                aborted = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (!rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    if (pmem_write) begin
                        if (e.wr) chk256("pmem_wdata_held", pmem_wdata, e.data);
                        for (int w = 0; w < 8; w++)
                            mem[pmem_address + 32'(4 * w)] = pmem_wdata[w*32 +: 32];
                    end else begin
                        pmem_rdata = line_of(pmem_address);
                    end
                    pmem_resp = 1'b1;
                    presp_cyc = cyc;
                end
            end
        end
    end

    // CPU response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst && mem_resp) begin
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_resp_unexpected: got resp at %h expected none", mem_address);
                end else begin
                    r = exp_q.pop_front();
                    if (r.is_rd) chk32(r.name, mem_rdata, r.rdata);
                end
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd,
                          input string name, output int waited);
        rsp_t r;
        r.is_rd = !wr; r.rdata = exp_rd; r.name = name;
        exp_q.push_back(r);
        mem_address = a; mem_read = !wr; mem_write = wr;
        mem_wdata = wd; mem_byte_enable = be;
        waited = 0;
        forever begin
            @(negedge clk);
            if (mem_resp) break;
            waited++;
            if (waited > 200) begin
                checks++; errors++;
                $display("FAIL %s_timeout: got no mem_resp expected one within 200 cycles", name);
                exp_q.delete();
                break;
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        int w;
        access(a, 1'b0, 32'h0, 4'h0, exp, name, w);
    endtask

    task automatic expect_fill(input logic [31:0] a);
        pop_t e;
        e.wr = 1'b0; e.addr = a; e.data = '0;
        pexp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected one before 200us");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int           w, n0;
        pop_t         e;
        logic [255:0] wbl;

        mem[32'h44] = 32'h1122_3344;
        #1;
        chk32("rst_mem_resp", 32'(mem_resp), 32'd0);
        chk32("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk32("rst_pmem_write", 32'(pmem_write), 32'd0);
        chk32("rst_hit_count", hit_count, 32'd0);
        chk32("rst_miss_count", miss_count, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Cold read: one fill, response one cycle after the fill completes.
        expect_fill(32'h0000_0040);
        rd(32'h0000_0040, 32'hC0DE_0040, "cold_rdata");
        chk32("cold_resp_lat", 32'(resp_cyc - presp_cyc), 32'd1);
        chk32("cold_miss_count", miss_count, 32'd1);
        chk32("cold_hit_count", hit_count, 32'd1);
        chk32("cold_pmem_ops", 32'(pmem_ops), 32'd1);

        // Byte-enable merge on a resident word.
        rd(32'h0000_0044, 32'h1122_3344, "resident_rdata");
        n0 = pmem_ops;
        access(32'h0000_0044, 1'b1, 32'hDEAD_BEEF, 4'b0101, 32'h0, "wr_merge", w);
        chk32("wr_hit_latency", 32'(w), 32'd0);
        rd(32'h0000_0044, 32'h11AD_33EF, "merged_rdata");
        chk32("merge_no_pmem", 32'(pmem_ops), 32'(n0));

        // Set 0: A,B,C,D fill ways 0..3, touch A, E must evict B (clean).
        expect_fill(32'h0000_0000); rd(32'h0000_0000, 32'hC0DE_0000, "fill_A");
        expect_fill(32'h0000_0100); rd(32'h0000_0100, 32'hC0DE_0100, "fill_B");
        expect_fill(32'h0000_0200); rd(32'h0000_0200, 32'hC0DE_0200, "fill_C");
        expect_fill(32'h0000_0300); rd(32'h0000_0300, 32'hC0DE_0300, "fill_D");
        rd(32'h0000_0000, 32'hC0DE_0000, "touch_A");
        expect_fill(32'h0000_0400); rd(32'h0000_0400, 32'hC0DE_0400, "fill_E");
        n0 = pmem_ops;
        rd(32'h0000_0000, 32'hC0DE_0000, "A_still_hit");
        rd(32'h0000_0200, 32'hC0DE_0200, "C_still_hit");
        rd(32'h0000_0300, 32'hC0DE_0300, "D_still_hit");
        chk32("plru_survivors_hit", 32'(pmem_ops), 32'(n0));
        expect_fill(32'h0000_0100); rd(32'h0000_0100, 32'hC0DE_0100, "B_refetch");
        chk32("B_was_victim", 32'(pmem_ops), 32'(n0 + 1));

        // Set 1: dirty P1 becomes the PLRU victim after touching P0, P3, P2.
        expect_fill(32'h0000_0020); rd(32'h0000_0020, 32'hC0DE_0020, "fill_P0");
        expect_fill(32'h0000_0120); rd(32'h0000_0120, 32'hC0DE_0120, "fill_P1");
        expect_fill(32'h0000_0220); rd(32'h0000_0220, 32'hC0DE_0220, "fill_P2");
        expect_fill(32'h0000_0320); rd(32'h0000_0320, 32'hC0DE_0320, "fill_P3");
        access(32'h0000_0120, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0, "wr_P1", w);
        rd(32'h0000_0020, 32'hC0DE_0020, "touch_P0");
        rd(32'h0000_0320, 32'hC0DE_0320, "touch_P3");
        rd(32'h0000_0220, 32'hC0DE_0220, "touch_P2");
        wbl = line_of(32'h0000_0120);
        wbl[31:0] = 32'hCAFE_F00D;
        e.wr = 1'b1; e.addr = 32'h0000_0120; e.data = wbl;
        pexp_q.push_back(e);
        expect_fill(32'h0000_0420);
        rd(32'h0000_0420, 32'hC0DE_0420, "fill_P4");
        expect_fill(32'h0000_0120);
        rd(32'h0000_0120, 32'hCAFE_F00D, "P1_writeback_data");

        // Reset during FILL abandons the miss without waiting for a clock.
        expect_fill(32'h0000_0500);
        mem_address = 32'h0000_0500; mem_read = 1'b1;
        w = 0;
        while (!pmem_read && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk32("rst_test_fill_seen", 32'(pmem_read), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk32("rst_async_pmem_read", 32'(pmem_read), 32'd0);
        chk32("rst_mid_hit_count", hit_count, 32'd0);
        chk32("rst_mid_miss_count", miss_count, 32'd0);
        mem_read = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        expect_fill(32'h0000_0500);
        rd(32'h0000_0500, 32'hC0DE_0500, "post_rst_refill");
        chk32("post_rst_miss_count", miss_count, 32'd1);
        chk32("post_rst_hit_count", hit_count, 32'd1);

        // Saturation of the hit counter.
        @(posedge clk); #1;
        force dut.hit_count_q = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.hit_count_q;
        rd(32'h0000_0500, 32'hC0DE_0500, "sat_hit1");
        chk32("sat_after_1", hit_count, 32'hFFFF_FFFF);
        rd(32'h0000_0500, 32'hC0DE_0500, "sat_hit2");
        rd(32'h0000_0500, 32'hC0DE_0500, "sat_hit3");
        chk32("sat_after_3", hit_count, 32'hFFFF_FFFF);

        repeat (5) @(posedge clk);
        chk32("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk32("pmem_queue_drained", 32'(pexp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
